// File: rtl/lfsr_pkg.sv
// Shared encodings for the LFSR self-test sequencer: traffic modes, FSM states, default seed.
package lfsr_pkg;

  typedef enum logic [1:0] {
    MODE_VALID  = 2'd0,
    MODE_V1I    = 2'd1,
    MODE_RELOCK = 2'd2,
    MODE_VI     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SRST = 2'd1,
    ST_RUN  = 2'd2,
    ST_EVAL = 2'd3
  } state_e;

  localparam logic [15:0] DEF_SEED_DFLT = 16'd300;

endpackage

// File: rtl/lfsr_pattern_gen.sv
// Valid/corrupt slot generator: pos walks 0..vm+im-1, slots at or beyond vm are corrupt.
// Latency: registered, one cycle from enable/restart; no backpressure (free-running while enabled).
module lfsr_pattern_gen #(
  parameter int PW = 8
) (
  input  logic          i_clk,
  input  logic          random_reset_flag,
  input  logic [PW-1:0] i_vm,
  input  logic [PW-1:0] i_im,
  input  logic          i_enable,
  input  logic          i_restart,
  output logic          o_corrupt,
  output logic [PW-1:0] o_pos
);

  logic [PW:0]   last_slot;
  logic [PW-1:0] pos_nxt;

  assign last_slot = {1'b0, i_vm} + {1'b0, i_im} - (PW+1)'(1);
  // >= rather than == so a shrinking period can never strand pos past the wrap point
  assign pos_nxt   = ({1'b0, o_pos} >= last_slot) ? '0 : o_pos + PW'(1);

  always_ff @(posedge i_clk or posedge random_reset_flag) begin
    if (random_reset_flag) begin
      o_pos     <= '0;
      o_corrupt <= 1'b0;
    end else if (i_restart) begin
      o_pos     <= '0;
      o_corrupt <= 1'b0;
    end else if (i_enable) begin
      o_pos     <= pos_nxt;
      o_corrupt <= (pos_nxt >= i_vm);
    end else begin
      o_corrupt <= 1'b0;
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Self-test sequencer for the LFSR generator/checker pair: seed load, soft reset, patterned traffic, verdict.
// Latency: o_done pulses SOFT_RST_CYCLES+RUN_CYCLES+1 cycles after SRST entry; no backpressure, i_start ignored while busy.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter logic [15:0] DEF_SEED          = DEF_SEED_DFLT,
  parameter int          VALID_TO_LOCK     = 5,
  parameter int          INVALID_TO_UNLOCK = 3,
  parameter int          SOFT_RST_CYCLES   = 4,
  parameter int          LOCK_TIMEOUT      = 64,
  parameter int          RUN_CYCLES        = 256
) (
  input  logic        i_clk,
  input  logic        random_reset_flag,
  input  logic        i_start,
  input  logic [1:0]  i_mode,
  input  logic [15:0] i_seed,
  input  logic        i_lock,
  output logic [15:0] o_seed,
  output logic        o_soft_reset,
  output logic        o_valid,
  output logic        o_corrupt,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [7:0]  o_unlock_cnt
);

  localparam int CW = $clog2(RUN_CYCLES + 1);
  localparam int SW = $clog2(SOFT_RST_CYCLES + 1);
  localparam int PW = 8;

  state_e        state_q, state_d;
  mode_e         mode_q;
  logic [SW-1:0] srst_cnt;
  logic [CW-1:0] cyc;
  logic [CW-1:0] first_lock_cyc;
  logic          lock_q, seen_lock, seen_unlock;
  logic          srst_last, run_last, first_lock, timely, pass_d;
  logic          gen_enable, gen_restart;
  logic [PW-1:0] vm, im, pos;

  assign srst_last  = (state_q == ST_SRST) && (srst_cnt == SW'(SOFT_RST_CYCLES - 1));
  assign run_last   = (state_q == ST_RUN) && (cyc == CW'(RUN_CYCLES - 1));
  assign first_lock = (state_q == ST_RUN) && i_lock && !seen_lock;
  assign timely     = seen_lock && (first_lock_cyc < CW'(LOCK_TIMEOUT));

  always_ff @(posedge i_clk or posedge random_reset_flag) begin
    if (random_reset_flag) state_q <= ST_IDLE;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start)   state_d = ST_SRST;
      ST_SRST: if (srst_last) state_d = ST_RUN;
      ST_RUN:  if (run_last)  state_d = ST_EVAL;
      ST_EVAL:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Relock mode switches to the sparse-valid pattern once the checker first locks
  always_comb begin
    vm = PW'(VALID_TO_LOCK);
    im = '0;
    case (mode_q)
      MODE_V1I: begin
        vm = PW'(VALID_TO_LOCK - 1);
        im = PW'(1);
      end
      MODE_RELOCK: if (seen_lock) begin
        vm = PW'(1);
        im = PW'(INVALID_TO_UNLOCK - 1);
      end
      MODE_VI: im = PW'(INVALID_TO_UNLOCK);
      default: ;
    endcase
  end

  always_comb begin
    pass_d = 1'b0;
    case (mode_q)
      MODE_VALID:  pass_d = timely && !seen_unlock && i_lock;
      MODE_V1I:    pass_d = !seen_lock;
      MODE_RELOCK: pass_d = timely && !seen_unlock;
      MODE_VI:     pass_d = timely && seen_unlock;
      default:     pass_d = 1'b0;
    endcase
  end

  assign gen_enable  = (state_q == ST_RUN) && (state_d == ST_RUN);
  assign gen_restart = (state_q != ST_RUN) || (first_lock && (mode_q == MODE_RELOCK));

  lfsr_pattern_gen #(.PW(PW)) u_pattern (
    .i_clk             (i_clk),
    .random_reset_flag (random_reset_flag),
    .i_vm              (vm),
    .i_im              (im),
    .i_enable          (gen_enable),
    .i_restart         (gen_restart),
    .o_corrupt         (o_corrupt),
    .o_pos             (pos)
  );

  always_ff @(posedge i_clk or posedge random_reset_flag) begin
    if (random_reset_flag) begin
      o_seed         <= DEF_SEED;
      o_soft_reset   <= 1'b0;
      o_valid        <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_pass         <= 1'b0;
      o_unlock_cnt   <= '0;
      mode_q         <= MODE_VALID;
      srst_cnt       <= '0;
      cyc            <= '0;
      first_lock_cyc <= '0;
      lock_q         <= 1'b0;
      seen_lock      <= 1'b0;
      seen_unlock    <= 1'b0;
    end else begin
      o_done       <= 1'b0;
      o_soft_reset <= (state_d == ST_SRST);
      o_valid      <= (state_d == ST_RUN);
      case (state_q)
        ST_IDLE: if (i_start) begin
          mode_q         <= mode_e'(i_mode);
          o_seed         <= (i_seed == '0) ? DEF_SEED : i_seed;
          o_pass         <= 1'b0;
          o_unlock_cnt   <= '0;
          o_busy         <= 1'b1;
          srst_cnt       <= '0;
          first_lock_cyc <= '0;
          seen_lock      <= 1'b0;
          seen_unlock    <= 1'b0;
        end
        ST_SRST: begin
          srst_cnt <= srst_cnt + SW'(1);
          cyc      <= '0;
          lock_q   <= 1'b0;
        end
        ST_RUN: begin
          cyc    <= cyc + CW'(1);
          lock_q <= i_lock;
          if (first_lock) begin
            seen_lock      <= 1'b1;
            first_lock_cyc <= cyc;
          end
          if (lock_q && !i_lock) begin
            seen_unlock <= 1'b1;
            if (o_unlock_cnt != 8'hFF) o_unlock_cnt <= o_unlock_cnt + 8'd1;
          end
        end
        ST_EVAL: begin
          o_pass <= pass_d;
          o_done <= 1'b1;
          o_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  slot_in_range: assert property (@(posedge i_clk) disable iff (random_reset_flag)
    (state_q == ST_RUN) |-> ({1'b0, pos} < ({1'b0, vm} + {1'b0, im})));

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: behavioural checker model drives i_lock, reference derives pattern and verdict.
module tb_lfsr_seq_ctrl;

  localparam int V  = 5;
  localparam int I  = 3;
  localparam int SR = 4;
  localparam int LT = 64;
  localparam int RC = 256;
  localparam logic [15:0] DS = 16'd300;

  localparam int LK_MODEL  = 0;
  localparam int LK_TIED0  = 1;
  localparam int LK_FORCE1 = 2;
  localparam int LK_STEP   = 3;
  localparam int LK_RAND   = 4;

  logic        i_clk = 1'b0;
  logic        random_reset_flag;
  logic        i_start;
  logic [1:0]  i_mode;
  logic [15:0] i_seed;
  logic        i_lock;
  logic [15:0] o_seed;
  logic        o_soft_reset, o_valid, o_corrupt, o_busy, o_done, o_pass;
  logic [7:0]  o_unlock_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   good_cnt, bad_cnt;
  logic env_lock;

  always #5 i_clk = ~i_clk;

  lfsr_seq_ctrl #(
    .DEF_SEED(DS), .VALID_TO_LOCK(V), .INVALID_TO_UNLOCK(I),
    .SOFT_RST_CYCLES(SR), .LOCK_TIMEOUT(LT), .RUN_CYCLES(RC)
  ) dut (
    .i_clk             (i_clk),
    .random_reset_flag (random_reset_flag),
    .i_start           (i_start),
    .i_mode            (i_mode),
    .i_seed            (i_seed),
    .i_lock            (i_lock),
    .o_seed            (o_seed),
    .o_soft_reset      (o_soft_reset),
    .o_valid           (o_valid),
    .o_corrupt         (o_corrupt),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_pass            (o_pass),
    .o_unlock_cnt      (o_unlock_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seed"},   o_seed, DS);
    chk({tag, "_srst"},   o_soft_reset, 1'b0);
    chk({tag, "_valid"},  o_valid, 1'b0);
    chk({tag, "_corr"},   o_corrupt, 1'b0);
    chk({tag, "_busy"},   o_busy, 1'b0);
    chk({tag, "_done"},   o_done, 1'b0);
    chk({tag, "_pass"},   o_pass, 1'b0);
    chk({tag, "_unlock"}, o_unlock_cnt, 8'd0);
  endtask

  // Checker model: lock after V consecutive clean words, unlock after I consecutive corrupt words
  task automatic env_step(input int src, input int c, input int arg);
    if (o_soft_reset) begin
      good_cnt = 0; bad_cnt = 0; env_lock = 1'b0;
    end else if (o_valid) begin
      if (!o_corrupt) begin
        bad_cnt = 0;
        if (!env_lock) begin
          good_cnt++;
          if (good_cnt >= V) begin env_lock = 1'b1; good_cnt = 0; end
        end
      end else begin
        good_cnt = 0;
        if (env_lock) begin
          bad_cnt++;
          if (bad_cnt >= I) begin env_lock = 1'b0; bad_cnt = 0; end
        end
      end
    end
    case (src)
      LK_TIED0:  i_lock = 1'b0;
      LK_FORCE1: i_lock = (c - SR == arg) ? 1'b1 : env_lock;
      LK_STEP:   i_lock = (c - SR >= arg);
      LK_RAND:   i_lock = 1'($urandom_range(0, 1));
      default:   i_lock = env_lock;
    endcase
  endtask

  function automatic logic exp_corrupt(input int mode, input int k, input int first_k);
    case (mode)
      1:       return (k % V) == V - 1;
      2:       return (first_k >= 0 && k > first_k) ? (((k - first_k - 1) % I) != 0) : 1'b0;
      3:       return (k % (V + I)) >= V;
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_test(input int mode, input logic [15:0] seed, input int src,
                          input int arg, input int poke);
    logic [15:0] exp_seed;
    int          first_k, unl, k;
    logic        prev_lock, lock_eval, timely, exp_pass, run;
    exp_seed  = (seed == 16'd0) ? DS : seed;
    first_k   = -1;
    unl       = 0;
    prev_lock = 1'b0;
    lock_eval = 1'b0;
    @(negedge i_clk);
    i_mode  = 2'(mode);
    i_seed  = seed;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int c = 0; c <= SR + RC + 2; c++) begin
      k   = c - SR;
      run = (c >= SR) && (c < SR + RC);
      chk("soft_reset", o_soft_reset, c < SR);
      chk("valid", o_valid, run);
      chk("corrupt", o_corrupt, run ? exp_corrupt(mode, k, first_k) : 1'b0);
      chk("busy", o_busy, c <= SR + RC);
      chk("done", o_done, c == SR + RC + 1);
      if (c == 0 || c == SR + RC + 1) chk("seed", o_seed, exp_seed);
      if (c == SR + RC + 1) begin
        timely = (first_k >= 0) && (first_k < LT);
        case (mode)
          0:       exp_pass = timely && unl == 0 && lock_eval;
          1:       exp_pass = first_k < 0;
          2:       exp_pass = timely && unl == 0;
          default: exp_pass = timely && unl >= 1;
        endcase
        chk("pass", o_pass, exp_pass);
        chk("unlock_cnt", o_unlock_cnt, (unl > 255) ? 255 : unl);
      end
      if (poke == 1 && c == SR + 50) begin
        i_start = 1'b1; i_mode = ~i_mode; i_seed = ~seed;
      end else if (poke == 2 && c == SR + RC) begin
        i_start = 1'b1; i_mode = ~i_mode;
      end else begin
        i_start = 1'b0;
      end
      env_step(src, c, arg);
      if (run) begin
        if (i_lock && first_k < 0) first_k = k;
        if (prev_lock && !i_lock) unl++;
        prev_lock = i_lock;
      end
      if (c == SR + RC) lock_eval = i_lock;
      @(negedge i_clk);
    end
  endtask

  task automatic run_reset_mid();
    int done_seen, busy_seen;
    done_seen = 0;
    busy_seen = 0;
    @(negedge i_clk);
    i_mode  = 2'd0;
    i_seed  = 16'($urandom_range(1, 65535));
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int c = 0; c < SR + 100; c++) begin
      env_step(LK_MODEL, c, 0);
      @(negedge i_clk);
    end
    chk("mid_in_run", o_valid, 1'b1);
    random_reset_flag = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge i_clk);
    random_reset_flag = 1'b0;
    good_cnt = 0; bad_cnt = 0; env_lock = 1'b0; i_lock = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge i_clk);
      if (o_done) done_seen++;
      if (o_busy) busy_seen++;
    end
    chk("mid_no_done", done_seen, 0);
    chk("mid_no_busy", busy_seen, 0);
  endtask

  initial begin
    int mode, src, arg, poke;
    logic [15:0] seed;
    random_reset_flag = 1'b1;
    i_start = 1'b0; i_mode = 2'd0; i_seed = 16'd0; i_lock = 1'b0;
    good_cnt = 0; bad_cnt = 0; env_lock = 1'b0;
    repeat (2) @(negedge i_clk);
    chk_reset_vals("por");
    random_reset_flag = 1'b0;
    @(negedge i_clk);

    run_test(0, 16'd0,    LK_MODEL,  0, 0);
    run_test(1, 16'hACE1, LK_MODEL,  0, 0);
    run_test(1, 16'hACE1, LK_FORCE1, $urandom_range(0, RC - 1), 0);
    run_test(2, 16'($urandom), LK_MODEL, 0, 0);
    run_test(3, 16'($urandom), LK_MODEL, 0, 1);
    run_test(0, 16'($urandom), LK_TIED0, 0, 0);
    run_test(0, 16'($urandom), LK_STEP, LT - 1, 0);
    run_test(0, 16'($urandom), LK_STEP, LT, 0);
    run_test(2, 16'($urandom), LK_TIED0, 0, 2);
    run_test(3, 16'($urandom), LK_STEP, 10, 0);
    run_reset_mid();
    run_test(0, 16'd0, LK_MODEL, 0, 0);

    for (int t = 0; t < 8; t++) begin
      mode = $urandom_range(0, 3);
      src  = $urandom_range(0, 4);
      poke = $urandom_range(0, 2);
      seed = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      case (src)
        LK_FORCE1: arg = $urandom_range(0, RC - 1);
        LK_STEP:   arg = $urandom_range(LT - 8, LT + 8);
        default:   arg = 0;
      endcase
      run_test(mode, seed, src, arg, poke);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
- Sequencer in front of the LFSR generator/checker pair (`top`).
- On a start pulse it loads a seed and applies a synchronous soft reset to the pair.
- It then drives a deterministic valid/corrupt traffic pattern selected by mode, watches the checker's lock flag, and reports pass/fail.
- It replaces the ad-hoc stimulus loop with a reusable, synthesizable controller for on-board self-test.

Parameters:
- DEF_SEED, 300: seed used when i_seed == 0.
- VALID_TO_LOCK, 5: checker valid count to lock; sets pattern lengths.
- INVALID_TO_UNLOCK, 3: checker invalid count to unlock; sets pattern lengths.
- SOFT_RST_CYCLES, 4: cycles o_soft_reset is held high.
- LOCK_TIMEOUT, 64: maximum RUN cycles allowed for first lock in modes 0, 2 and 3.
- RUN_CYCLES, 256: length of the traffic phase. Must be >= 2*LOCK_TIMEOUT.

Ports:
- i_clk, in, 1: clock.
- random_reset_flag, in, 1: reset, asynchronous, active-high; clock i_clk.
- i_start, in, 1: single-cycle start pulse.
- i_mode, in, 2: 0 = valid traffic; 1 = (V-1) valid / 1 corrupt; 2 = lock, then 1 valid / (I-1) corrupt; 3 = V valid / I corrupt.
- i_seed, in, 16: requested seed.
- i_lock, in, 1: checker lock flag.
- o_seed, out, 16: seed driven to the generator.
- o_soft_reset, out, 1: synchronous reset to the generator/checker.
- o_valid, out, 1: generator enable.
- o_corrupt, out, 1: corrupt request for the current valid word.
- o_busy, out, 1: high from start until DONE.
- o_done, out, 1: one-cycle pulse at end of test.
- o_pass, out, 1: verdict; held until the next start.
- o_unlock_cnt, out, 8: number of 1->0 transitions of i_lock during RUN; saturates at 255.

Behaviour:
- Reset values: o_seed = DEF_SEED; o_pass = 0, o_unlock_cnt = 0; every other output = 0; FSM = IDLE.
- All outputs are registered.
- FSM states: IDLE -> SRST -> RUN -> EVAL -> IDLE.
- IDLE:
  - i_start = 1 latches i_mode into mode_q.
  - It latches o_seed = (i_seed == 0 ? DEF_SEED : i_seed).
  - It clears o_pass and o_unlock_cnt and goes to SRST.
  - i_start in any other state is ignored.
- SRST:
  - o_soft_reset = 1 for exactly SOFT_RST_CYCLES cycles; o_valid = 0.
  - Then go to RUN with the cycle counter cleared.
- RUN:
  - o_valid = 1 every cycle, for RUN_CYCLES cycles.
  - Slot counter pos counts 0..(Vm+Im-1) and wraps.
  - o_corrupt = (pos >= Vm).
  - Per-mode (Vm, Im): mode0 = (V, 0); mode1 = (V-1, 1); mode3 = (V, I).
  - Mode2 phase A = (V, 0) until the first i_lock = 1. Phase B = (1, I-1): pos resets to 0 the cycle after lock is first seen.
- Lock tracking in RUN:
  - Flags: seen_lock and seen_unlock; o_unlock_cnt increments on each falling edge of i_lock.
  - first_lock_cyc is recorded from the cycle counter.
  - Edges are detected against a registered i_lock sample, which is cleared in SRST.
- EVAL (one cycle): sets o_pass, pulses o_done, drops o_busy, returns to IDLE. Pass criteria:
  - mode0: seen_lock, first_lock_cyc < LOCK_TIMEOUT, o_unlock_cnt == 0, and i_lock = 1.
  - mode1: !seen_lock.
  - mode2: seen_lock within timeout, and o_unlock_cnt == 0.
  - mode3: seen_lock within timeout, and o_unlock_cnt >= 1.
- Boundary conditions:
  - Cycle counter width is clog2(RUN_CYCLES+1).
  - A lock seen at exactly cycle LOCK_TIMEOUT counts as a timeout (fail).
  - In mode2 with no lock in RUN, phase B never starts and the test fails.
  - Asserting random_reset_flag mid-test returns the FSM to IDLE immediately. o_soft_reset drops, and no o_done is produced.
  - i_start in the same cycle that EVAL completes is ignored; the FSM is in IDLE one cycle later.

Decomposition:
- Package lfsr_pkg holds:
  - mode encodings MODE_VALID, MODE_V1I, MODE_RELOCK, MODE_VI;
  - FSM state encodings;
  - DEF_SEED default.
- Sub-module lfsr_pattern_gen: takes (Vm, Im, enable, restart) and produces o_corrupt and pos.
- FSM and verdict logic stay in lfsr_seq_ctrl.

Test Plan:
- Mode0, i_seed = 0, checker-model lock after 5 clean words -> o_seed = 300; o_soft_reset high 4 cycles; o_done at cycle 4+256+1 after SRST entry; o_pass = 1; o_unlock_cnt = 0.
- Mode1, i_seed = 0xACE1 -> corrupt every 5th word; lock never asserts; o_pass = 1. Forcing i_lock = 1 once -> o_pass = 0.
- Mode2 -> lock at ~cycle 5; then pattern V,C,C repeats; lock held; o_pass = 1, o_unlock_cnt = 0.
- Mode3 -> pattern VVVVVCCC; lock toggles; o_unlock_cnt >= 30; o_pass = 1.
- i_lock tied 0 in mode0 -> o_pass = 0 at EVAL.
- random_reset_flag pulsed at RUN cycle 100 -> all outputs to reset values at once; o_seed = 300; no o_done; next i_start runs normally.
